weight_fetch_ctrl: RTL and testbench
====================================

Name: weight_fetch_ctrl

Overview:
- Read-side controller for the conv weight SRAM (216 weights x 8 b per address, 411 addresses). The conv engine requests a run of consecutive weight words.
- The block drives the SRAM read port (csb/raddr) and captures each rdata word into a 2-entry buffer.
- It presents words downstream on a valid/ready stream with a last flag, sustaining one word per cycle when the consumer is always ready.

Parameters:
- WEIGHT_PER_ADDR, 216, weights per SRAM word
- BW_PER_WEIGHT, 8, bits per weight
- ADDR_W, 9, SRAM address width
- MEM_DEPTH, 411, valid SRAM addresses 0..MEM_DEPTH-1
- BUF_DEPTH, 2, output buffer entries (fixed at 2)

Ports:
- clk  in  1  system clock; SRAM port samples on negedge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request pulse; sampled only in IDLE
- base_addr  in  ADDR_W  first SRAM address of the run
- num_words  in  ADDR_W  words to fetch (0..MEM_DEPTH)
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse after the last word handshakes
- cfg_err  out  1  one-cycle pulse when a request is rejected
- sram_csb  out  1  SRAM chip enable, active low
- sram_wsb  out  1  SRAM write enable, tied 1 (never writes)
- sram_raddr  out  ADDR_W  SRAM read address
- sram_rdata  in  WEIGHT_PER_ADDR*BW_PER_WEIGHT  SRAM read data, valid one posedge after issue
- w_valid  out  1  buffer head valid
- w_ready  in  1  consumer accepts head
- w_data  out  WEIGHT_PER_ADDR*BW_PER_WEIGHT  weight word
- w_last  out  1  head is the final word of the run

Behaviour:
- Reset values (async, rst_n low): state=IDLE, busy=0, done=0, cfg_err=0, sram_csb=1, sram_raddr=0, w_valid=0, w_last=0, buffer count=0, inflight=0. w_data need not be reset.
- A reset mid-run discards the buffer and in-flight read; no done pulse is produced.
- State IDLE, on start:
  - If base_addr+num_words > MEM_DEPTH (ADDR_W+1-bit sum), pulse cfg_err the next cycle and stay in IDLE.
  - Else if num_words==0, pulse done the next cycle and stay in IDLE, with no SRAM access.
  - Else latch base_addr and num_words, set busy, and go to FETCH.
- State FETCH, read issue:
  - In cycle t, a read issues iff issued<num_words and (count + inflight - pop_t) < BUF_DEPTH, where pop_t = w_valid & w_ready.
  - An issue drives sram_csb=0 and sram_raddr=base+issued, registered at posedge t.
  - The SRAM samples at the following negedge. rdata is pushed into the buffer at posedge t+1 (inflight=1 for exactly one cycle).
  - sram_csb=1 whenever no read issues.
  - After the last issue, go to DRAIN.
- State DRAIN: no issues. When the word flagged last handshakes, go to DONE.
- State DONE: pulse done for one cycle, clear busy, return to IDLE. start is accepted again the cycle after done.
- start is ignored while busy (not queued, no cfg_err).
- Buffer:
  - 2-entry FIFO; head drives w_data and w_last; w_valid = count!=0.
  - Push and pop in the same cycle leaves count unchanged.
  - The issue rule guarantees no push into a full buffer. Overflow is a design error; the bench asserts it never occurs.
- Stream rules:
  - w_data and w_last hold stable while w_valid & ~w_ready.
  - w_last is set only on the word fetched from base+num_words-1.
- Latency and throughput:
  - First w_valid is 2 cycles after the accepted start (start edge -> issue register -> buffer push).
  - With w_ready stuck at 1, one word per cycle, and a run of N words completes in N+2 cycles, plus 1 for done.
- Addresses stay below MEM_DEPTH, so the address never wraps.

Decomposition:
- Shared package wfc_pkg:
  - state enum (IDLE, FETCH, DRAIN, DONE)
  - WDATA_W = WEIGHT_PER_ADDR*BW_PER_WEIGHT
  - MEM_DEPTH and ADDR_W constants, shared with the SRAM model and conv engine.
- One sub-module: wfc_skid_fifo, the 2-entry valid/ready buffer carrying {last, data}. Issue counter and FSM stay in the top.

Test Plan:
- SRAM preloaded with mem[i] = {216{i[7:0]}}; start base=0, num=24, w_ready=1 -> 24 words with bytes 0..23 on consecutive cycles; first w_valid 2 cycles after start; w_last only on word 23; done pulses once; busy low afterward.
- base=100, num=5, w_ready toggling 1,0,0,1,... -> words 100..104 delivered in order with none lost or duplicated; w_data stable while stalled; no buffer overflow; sram_csb=1 while the buffer is full.
- base=400, num=12 -> cfg_err pulse, no csb activity, busy stays 0. base=399, num=12 -> accepted; last word is 410.
- num=0 -> done one cycle later, no SRAM read, busy never asserts. A second start while busy on a 24-word run is ignored.
- rst_n asserted mid-run (after word 7 of 24) -> all outputs return to reset values immediately; no done. A new start base=0, num=3 then completes normally.
- w_ready held 0 for 10 cycles after start with num=4 -> exactly 2 reads issued; then w_ready=1 -> remaining 2 words fetched at full rate; done after word 3.

Source files
------------

// File: rtl/wfc_pkg.sv
// Shared constants and state encoding for the conv weight fetch path.
// Also used by the SRAM model and the conv engine.
package wfc_pkg;

    localparam int WEIGHT_PER_ADDR = 216;
    localparam int BW_PER_WEIGHT   = 8;
    localparam int WDATA_W         = WEIGHT_PER_ADDR * BW_PER_WEIGHT;
    localparam int ADDR_W          = 9;
    localparam int MEM_DEPTH       = 411;
    localparam int BUF_DEPTH       = 2;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN,
        DONE
    } state_t;

endpackage

// File: rtl/wfc_skid_fifo.sv
// Two-entry valid/ready buffer carrying {last, data} from the SRAM read
// port to the weight stream consumer.
module wfc_skid_fifo #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          push_last,
    input  logic          out_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    output logic [1:0]    count
);

    logic [DW:0] mem [0:1];
    logic        wr_ptr;
    logic        rd_ptr;
    logic        pop;

    assign out_valid = (count != 2'd0);
    assign out_data  = mem[rd_ptr][DW-1:0];
    assign out_last  = out_valid & mem[rd_ptr][DW];
    assign pop       = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Payload storage is not reset; the occupancy count alone decides validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {push_last, push_data};
        end
    end

endmodule

// File: rtl/weight_fetch_ctrl.sv
// Read-side controller for the conv weight SRAM: issues a run of consecutive
// reads and streams the returned words downstream with a last flag.
module weight_fetch_ctrl
    import wfc_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [ADDR_W-1:0]  base_addr,
    input  logic [ADDR_W-1:0]  num_words,
    output logic               busy,
    output logic               done,
    output logic               cfg_err,
    output logic               sram_csb,
    output logic               sram_wsb,
    output logic [ADDR_W-1:0]  sram_raddr,
    input  logic [WDATA_W-1:0] sram_rdata,
    output logic               w_valid,
    input  logic               w_ready,
    output logic [WDATA_W-1:0] w_data,
    output logic               w_last
);

    localparam logic [ADDR_W:0]   MEM_LIMIT = (ADDR_W + 1)'(MEM_DEPTH);
    localparam logic [2:0]        BUF_LIMIT = 3'(BUF_DEPTH);
    localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);

    state_t            state;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] num_q;
    logic [ADDR_W-1:0] issued;
    logic              inflight;
    logic              inflight_last;
    logic [1:0]        fifo_count;

    logic [ADDR_W:0]   req_end;
    logic              pop;
    logic [2:0]        occupancy;
    logic              issue;
    logic              last_issue;

    assign sram_wsb   = 1'b1;
    assign req_end    = {1'b0, base_addr} + {1'b0, num_words};
    assign pop        = w_valid & w_ready;
    assign occupancy  = {1'b0, fifo_count} + {2'b00, inflight};
    // A slot freed by this cycle's pop may be refilled by the read issued now.
    assign issue      = (state == FETCH) && (issued < num_q) &&
                        (occupancy < (BUF_LIMIT + {2'b00, pop}));
    assign last_issue = (issued == (num_q - ONE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            cfg_err       <= 1'b0;
            sram_csb      <= 1'b1;
            sram_raddr    <= '0;
            base_q        <= '0;
            num_q         <= '0;
            issued        <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            done     <= 1'b0;
            cfg_err  <= 1'b0;
            sram_csb <= 1'b1;
            inflight <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (req_end > MEM_LIMIT) begin
                            cfg_err <= 1'b1;
                        end else if (num_words == '0) begin
                            done <= 1'b1;
                        end else begin
                            base_q <= base_addr;
                            num_q  <= num_words;
                            issued <= '0;
                            busy   <= 1'b1;
                            state  <= FETCH;
                        end
                    end
                end
                FETCH: begin
                    if (issue) begin
                        sram_csb      <= 1'b0;
                        sram_raddr    <= base_q + issued;
                        issued        <= issued + ONE;
                        inflight      <= 1'b1;
                        inflight_last <= last_issue;
                        if (last_issue) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (pop && w_last) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    wfc_skid_fifo #(
        .DW(WDATA_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (inflight),
        .push_data (sram_rdata),
        .push_last (inflight_last),
        .out_ready (w_ready),
        .out_valid (w_valid),
        .out_data  (w_data),
        .out_last  (w_last),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_weight_fetch_ctrl.sv
// Self-checking bench for weight_fetch_ctrl: table vectors, random runs and
// multi-cycle corner sequences against a queue-based reference model.
module tb_weight_fetch_ctrl;
    import wfc_pkg::*;

    typedef struct {
        int base;
        int num;
        int mode;
        int exp_cfg;
        int exp_done;
        int exp_words;
        int exp_lat;
    } vec_t;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               start;
    logic [ADDR_W-1:0]  base_addr;
    logic [ADDR_W-1:0]  num_words;
    logic               busy;
    logic               done;
    logic               cfg_err;
    logic               sram_csb;
    logic               sram_wsb;
    logic [ADDR_W-1:0]  sram_raddr;
    logic [WDATA_W-1:0] sram_rdata = '0;
    logic               w_valid;
    logic               w_ready;
    logic [WDATA_W-1:0] w_data;
    logic               w_last;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    int reads, words, done_cnt, cfg_cnt, done_cyc, cfg_cyc, first_valid_cyc, start_cyc;
    bit busy_seen;
    bit stalled = 1'b0;
    bit held_last;
    logic [WDATA_W-1:0] held_data;
    int raddr_q[$];
    int word_q[$];
    int exp_a, act_b;
    vec_t table_q[$];

    weight_fetch_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .base_addr  (base_addr),
        .num_words  (num_words),
        .busy       (busy),
        .done       (done),
        .cfg_err    (cfg_err),
        .sram_csb   (sram_csb),
        .sram_wsb   (sram_wsb),
        .sram_raddr (sram_raddr),
        .sram_rdata (sram_rdata),
        .w_valid    (w_valid),
        .w_ready    (w_ready),
        .w_data     (w_data),
        .w_last     (w_last)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // SRAM model: word i holds byte i[7:0] in every weight slot.
    always @(negedge clk) begin
        if (!sram_csb) sram_rdata <= {WEIGHT_PER_ADDR{sram_raddr[7:0]}};
    end

    task automatic checkOutput(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t modelVec(input int base, input int num, input int mode);
        vec_t v;
        bit err;
        err         = (base + num) > MEM_DEPTH;
        v.base      = base;
        v.num       = num;
        v.mode      = mode;
        v.exp_cfg   = err ? 1 : 0;
        v.exp_done  = err ? 0 : 1;
        v.exp_words = err ? 0 : num;
        v.exp_lat   = (mode == 0 && !err) ? ((num == 0) ? 0 : num + 2) : -1;
        return v;
    endfunction

    // Stream monitor: every read address and every delivered word is checked
    // against the expected run held in the queues.
    always @(negedge clk) begin
        if (!rst_n) begin
            stalled = 1'b0;
        end else begin
            if (!sram_csb) begin
                reads++;
                if (raddr_q.size() == 0) begin
                    checkOutput("raddr_extra", int'(sram_raddr), -1);
                end else begin
                    exp_a = raddr_q.pop_front();
                    checkOutput("sram_raddr", int'(sram_raddr), exp_a);
                end
            end
            if (w_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (stalled && w_valid)
                checkOutput("hold_stable", int'(w_data == held_data && w_last == held_last), 1);
            if (w_valid) checkOutput("outstanding_le2", int'((reads - words) <= 2), 1);
            if (w_valid && w_ready) begin
                if (word_q.size() == 0) begin
                    checkOutput("word_extra", int'(w_data[7:0]), -1);
                end else begin
                    exp_a = word_q.pop_front();
                    act_b = (w_data == {WEIGHT_PER_ADDR{w_data[7:0]}}) ? int'(w_data[7:0]) : 999;
                    checkOutput("w_data", act_b, exp_a % 256);
                    checkOutput("w_last", int'(w_last), int'(word_q.size() == 0));
                end
                words++;
            end
            stalled   = w_valid && !w_ready;
            held_data = w_data;
            held_last = w_last;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (cfg_err) begin
                cfg_cnt++;
                cfg_cyc = cyc;
            end
            if (busy) busy_seen = 1'b1;
        end
    end

    task automatic beginRun(input int base, input int num, input int mode);
        raddr_q.delete();
        word_q.delete();
        if ((base + num) <= MEM_DEPTH) begin
            for (int i = 0; i < num; i++) begin
                raddr_q.push_back(base + i);
                word_q.push_back(base + i);
            end
        end
        reads = 0; words = 0; done_cnt = 0; cfg_cnt = 0;
        done_cyc = -1; cfg_cyc = -1; first_valid_cyc = -1;
        busy_seen = 1'b0;
        w_ready   = (mode == 3) ? 1'b0 : 1'b1;
        base_addr = ADDR_W'(base);
        num_words = ADDR_W'(num);
        start     = 1'b1;
        tick();
        start_cyc = cyc;
        start     = 1'b0;
    endtask

    task automatic finishRun(input int mode, input int budget);
        for (int k = 0; k < budget && done_cnt == 0 && cfg_cnt == 0; k++) begin
            case (mode)
                1:       w_ready = ((k % 3) == 0);
                2:       w_ready = 1'($urandom_range(0, 1));
                default: w_ready = 1'b1;
            endcase
            tick();
        end
        w_ready = 1'b1;
        repeat (3) tick();
    endtask

    task automatic applyStimulus(input vec_t v);
        beginRun(v.base, v.num, v.mode);
        finishRun(v.mode, v.num * 8 + 40);
        checkOutput("cfg_err_pulses", cfg_cnt, v.exp_cfg);
        checkOutput("done_pulses", done_cnt, v.exp_done);
        checkOutput("words_delivered", words, v.exp_words);
        checkOutput("sram_reads", reads, v.exp_words);
        checkOutput("busy_seen", int'(busy_seen), int'(v.exp_words > 0));
        if (v.exp_cfg == 1) checkOutput("cfg_err_latency", cfg_cyc - start_cyc, 0);
        if (v.exp_lat >= 0) checkOutput("done_latency", done_cyc - start_cyc, v.exp_lat);
        if (v.mode == 0 && v.exp_words > 0)
            checkOutput("first_valid_latency", first_valid_cyc - start_cyc, 2);
        checkOutput("busy_after", int'(busy), 0);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_busy"}, int'(busy), 0);
        checkOutput({tag, "_done"}, int'(done), 0);
        checkOutput({tag, "_cfg_err"}, int'(cfg_err), 0);
        checkOutput({tag, "_csb"}, int'(sram_csb), 1);
        checkOutput({tag, "_wsb"}, int'(sram_wsb), 1);
        checkOutput({tag, "_raddr"}, int'(sram_raddr), 0);
        checkOutput({tag, "_w_valid"}, int'(w_valid), 0);
        checkOutput({tag, "_w_last"}, int'(w_last), 0);
    endtask

    initial begin
        int base, num, mode, release_cyc;
        rst_n = 1'b0; start = 1'b0; base_addr = '0; num_words = '0; w_ready = 1'b0;
        reads = 0; words = 0; done_cnt = 0; cfg_cnt = 0;

        // Table: base, num, ready mode, cfg_err, done, words, done latency.
        table_q.push_back('{0,   24,  0, 0, 1, 24,  26});
        table_q.push_back('{100, 5,   1, 0, 1, 5,   -1});
        table_q.push_back('{400, 12,  0, 1, 0, 0,   -1});
        table_q.push_back('{399, 12,  0, 0, 1, 12,  14});
        table_q.push_back('{0,   0,   0, 0, 1, 0,   0});
        table_q.push_back('{410, 1,   0, 0, 1, 1,   3});
        table_q.push_back('{411, 0,   0, 0, 1, 0,   0});
        table_q.push_back('{1,   411, 0, 1, 0, 0,   -1});
        table_q.push_back('{511, 511, 0, 1, 0, 0,   -1});
        table_q.push_back('{0,   411, 0, 0, 1, 411, 413});

        #12;
        checkResetOutputs("reset");
        tick();
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < table_q.size(); i++) applyStimulus(table_q[i]);

        // Starts while busy are dropped without cfg_err.
        beginRun(0, 24, 0);
        repeat (5) tick();
        base_addr = 9'd400; num_words = 9'd50; start = 1'b1;
        tick();
        base_addr = 9'd3; num_words = 9'd2;
        tick();
        start = 1'b0;
        finishRun(0, 100);
        checkOutput("busy_start_cfg_err", cfg_cnt, 0);
        checkOutput("busy_start_done", done_cnt, 1);
        checkOutput("busy_start_words", words, 24);
        checkOutput("busy_start_latency", done_cyc - start_cyc, 26);

        // Consumer stalled: only two reads fit, then full rate on release.
        beginRun(50, 4, 3);
        repeat (10) tick();
        checkOutput("stall_reads", reads, 2);
        checkOutput("stall_words", words, 0);
        checkOutput("stall_csb_idle", int'(sram_csb), 1);
        release_cyc = cyc;
        finishRun(0, 40);
        checkOutput("stall_words_total", words, 4);
        checkOutput("stall_done", done_cnt, 1);
        checkOutput("stall_release_latency", done_cyc - release_cyc, 4);

        // Reset mid-run after word 7: everything returns to idle, no done.
        beginRun(0, 24, 0);
        for (int k = 0; k < 200 && words < 8; k++) tick();
        checkOutput("midrun_reached_word8", int'(words >= 8), 1);
        tick();
        #2 rst_n = 1'b0;
        #1;
        checkResetOutputs("midrun_reset");
        raddr_q.delete();
        word_q.delete();
        tick();
        tick();
        rst_n = 1'b1;
        done_cnt = 0;
        repeat (5) tick();
        checkOutput("midrun_no_done", done_cnt, 0);
        checkOutput("midrun_idle_csb", int'(sram_csb), 1);
        applyStimulus('{0, 3, 0, 0, 1, 3, 5});

        // Random runs against the reference model.
        for (int i = 0; i < 16; i++) begin
            mode = int'($urandom_range(0, 2));
            if ((i % 4) == 0) begin
                base = int'($urandom_range(360, 411));
                num  = MEM_DEPTH - base;
            end else begin
                base = int'($urandom_range(0, 511));
                num  = int'($urandom_range(0, 40));
            end
            applyStimulus(modelVec(base, num, mode));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
